// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants and FSM encoding for the clock divider
package clk_div_pkg;

    localparam int          W_DEF       = 32;
    localparam int unsigned N_RESET_DEF = 50000000;
    localparam int unsigned N_MIN       = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/clk_div_ctrl_if.sv
// rtl/clk_div_ctrl_if.sv - ratio configuration handshake (valid/ready plus ratio)
interface clk_div_ctrl_if #(
    parameter int W = clk_div_pkg::W_DEF
) ();

    logic         cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] cfg_n;

    modport master (
        output cfg_valid,
        output cfg_n,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_n,
        output cfg_ready
    );

endinterface

// File: rtl/clk_div_core.sv
// rtl/clk_div_core.sv - period counter, half-period compare and tick generation
module clk_div_core #(
    parameter int W = clk_div_pkg::W_DEF
) (
    input  logic         CLK,
    input  logic         RST_n,
    input  logic         run,
    input  logic [W-1:0] n_cur,
    output logic         last,
    output logic         div_out,
    output logic         tick
);

    logic [W-1:0] cnt;
    logic [W:0]   half;

    // One extra bit keeps (n_cur + 1) from overflowing for n_cur = 2^W-1.
    assign half = ({1'b0, n_cur} + (W + 1)'(1)) >> 1;
    assign last = (cnt == (n_cur - W'(1)));

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            cnt     <= '0;
            div_out <= 1'b0;
            tick    <= 1'b0;
        end else if (run) begin
            cnt     <= last ? '0 : cnt + W'(1);
            div_out <= ({1'b0, cnt} < half);
            tick    <= last;
        end else begin
            cnt     <= '0;
            div_out <= 1'b0;
            tick    <= 1'b0;
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - run/drain FSM, ratio handshake and pending-ratio register
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int           W       = W_DEF,
    parameter logic [W-1:0] N_RESET = W'(N_RESET_DEF)
) (
    input  logic          CLK,
    input  logic          RST_n,
    input  logic          en,
    clk_div_ctrl_if.slave cfg,
    output logic          div_out,
    output logic          tick,
    output logic          busy,
    output logic          err
);

    state_t       state;
    state_t       state_nxt;
    logic [W-1:0] n_cur;
    logic [W-1:0] n_pend;
    logic         pend;
    logic         run;
    logic         last;
    logic         wrap;
    logic         xfer;
    logic         legal;

    assign cfg.cfg_ready = !pend;
    assign xfer          = cfg.cfg_valid && !pend;
    assign legal         = (cfg.cfg_n >= W'(N_MIN));
    assign run           = (state != IDLE);
    assign busy          = run;
    assign wrap          = run && last;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = RUN;
            RUN:     if (!en) state_nxt = wrap ? IDLE : DRAIN;
            DRAIN: begin
                if (en)        state_nxt = RUN;
                else if (wrap) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // n_cur only moves while stopped or on a wrap, so a period is never cut short.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            n_cur  <= N_RESET;
            n_pend <= '0;
            pend   <= 1'b0;
            err    <= 1'b0;
        end else begin
            err <= xfer && !legal;
            if (!run) begin
                if (xfer && legal) n_cur <= cfg.cfg_n;
            end else if (wrap) begin
                pend <= 1'b0;
                if (xfer && legal) n_cur <= cfg.cfg_n;
                else if (pend)     n_cur <= n_pend;
            end else if (xfer && legal) begin
                n_pend <= cfg.cfg_n;
                pend   <= 1'b1;
            end
        end
    end

    clk_div_core #(.W(W)) u_core (
        .CLK     (CLK),
        .RST_n   (RST_n),
        .run     (run),
        .n_cur   (n_cur),
        .last    (last),
        .div_out (div_out),
        .tick    (tick)
    );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - directed self-checking bench for clk_div_ctrl
module tb_clk_div_ctrl;

    logic CLK;
    logic RST_n;
    logic en;
    logic div_out;
    logic tick;
    logic busy;
    logic err;

    int n_tests = 0;
    int n_fail  = 0;

    clk_div_ctrl_if #(.W(32)) cfg_if ();

    clk_div_ctrl #(.W(32), .N_RESET(32'd4)) dut (
        .CLK     (CLK),
        .RST_n   (RST_n),
        .en      (en),
        .cfg     (cfg_if),
        .div_out (div_out),
        .tick    (tick),
        .busy    (busy),
        .err     (err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Checks div_out/tick against hand-written strings, one character per cycle.
    task automatic wave(input string tag, input string d, input string t);
        for (int i = 0; i < d.len(); i++) begin
            chk($sformatf("%s div[%0d]", tag, i), div_out, d[i] == "1");
            chk($sformatf("%s tick[%0d]", tag, i), tick, t[i] == "1");
            @(negedge CLK);
        end
    endtask

    initial begin
        RST_n            = 1'b0;
        en               = 1'b1;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_n     = '0;

        @(negedge CLK);
        chk("rst div", div_out, 1'b0);
        chk("rst tick", tick, 1'b0);
        chk("rst busy", busy, 1'b0);
        chk("rst err", err, 1'b0);
        chk("rst ready", cfg_if.cfg_ready, 1'b1);
        RST_n = 1'b1;
        @(negedge CLK);
        chk("start busy", busy, 1'b1);
        chk("start div", div_out, 1'b0);
        @(negedge CLK);
        wave("n4", "11001100", "00010001");

        // queue N=5 mid-period; it lands after the current N=4 period
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_n     = 32'd5;
        wave("n4a", "1", "0");
        cfg_if.cfg_valid = 1'b0;
        chk("pend5 ready0", cfg_if.cfg_ready, 1'b0);
        wave("n4b", "1", "0");
        chk("pend5 ready1", cfg_if.cfg_ready, 1'b0);
        wave("n4c", "0", "0");
        chk("wrap5 ready", cfg_if.cfg_ready, 1'b1);
        wave("n4d", "0", "1");
        wave("n5", "11100", "00001");

        // N=2 offered mid-period of N=5
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_n     = 32'd2;
        wave("n5to2a", "1", "0");
        cfg_if.cfg_valid = 1'b0;
        chk("pend2 ready", cfg_if.cfg_ready, 1'b0);
        wave("n5to2b", "11001010", "00010101");

        // illegal ratios
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_n     = 32'd1;
        wave("bad1a", "1", "0");
        cfg_if.cfg_valid = 1'b0;
        chk("bad1 err", err, 1'b1);
        chk("bad1 ready", cfg_if.cfg_ready, 1'b1);
        wave("bad1b", "0", "1");
        chk("bad1 err clr", err, 1'b0);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_n     = 32'd0;
        wave("bad0a", "1", "0");
        cfg_if.cfg_valid = 1'b0;
        chk("bad0 err", err, 1'b1);
        wave("bad0b", "0", "1");
        chk("bad0 err clr", err, 1'b0);
        wave("n2keep", "1010", "0101");

        // N=6 offered on the N=2 wrap cycle bypasses the pending slot
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_n     = 32'd6;
        wave("n2to6a", "1", "0");
        cfg_if.cfg_valid = 1'b0;
        chk("byp6 ready", cfg_if.cfg_ready, 1'b1);
        wave("n2to6b", "0", "1");
        wave("n6", "1110001", "0000010");

        // en dropped at cnt=2: period completes, then IDLE
        en = 1'b0;
        wave("drain a", "11", "00");
        chk("drain busy", busy, 1'b1);
        wave("drain b", "00", "00");
        chk("drain idle busy", busy, 1'b0);
        wave("drain c", "000", "100");

        // restart, then en dropped on the wrap cycle
        en = 1'b1;
        wave("rerun a", "0", "0");
        chk("rerun busy", busy, 1'b1);
        wave("rerun b", "01110", "00000");
        en = 1'b0;
        wave("stopwrap a", "0", "0");
        chk("stopwrap busy", busy, 1'b0);
        wave("stopwrap b", "00", "10");

        // load N=8 while idle, then N=3 on the exact wrap cycle
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_n     = 32'd8;
        @(negedge CLK);
        cfg_if.cfg_valid = 1'b0;
        chk("idle8 ready", cfg_if.cfg_ready, 1'b1);
        en = 1'b1;
        @(negedge CLK);
        wave("n8", "0111100", "0000000");
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_n     = 32'd3;
        wave("n8wrap", "0", "0");
        chk("byp3 ready", cfg_if.cfg_ready, 1'b1);
        cfg_if.cfg_n = 32'd4;
        wave("n8end", "0", "1");
        cfg_if.cfg_valid = 1'b0;
        chk("pend4 ready", cfg_if.cfg_ready, 1'b0);
        wave("n3n4", "1101100", "0010001");

        // N=10 active, N=7 pending, then asynchronous reset at cnt=3
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_n     = 32'd10;
        wave("to10a", "1", "0");
        cfg_if.cfg_valid = 1'b0;
        wave("to10b", "100", "001");
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_n     = 32'd7;
        wave("n10a", "1", "0");
        cfg_if.cfg_valid = 1'b0;
        chk("pend7 ready", cfg_if.cfg_ready, 1'b0);
        wave("n10b", "1", "0");
        chk("pre-rst div", div_out, 1'b1);
        RST_n = 1'b0;
        #1;
        chk("async div", div_out, 1'b0);
        chk("async tick", tick, 1'b0);
        chk("async busy", busy, 1'b0);
        chk("async err", err, 1'b0);
        chk("async ready", cfg_if.cfg_ready, 1'b1);
        @(negedge CLK);
        RST_n = 1'b1;
        chk("post-rst ready", cfg_if.cfg_ready, 1'b1);
        @(negedge CLK);
        chk("post-rst busy", busy, 1'b1);
        wave("post-rst n4", "011001100", "000010001");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
